// File: rtl/cpu86_exec_trace_checker.sv
// Lock-step retire-trace checker for the cpu86 exec stage: buffers DUT records, pairs them
// with golden-model records, drops wrong-path records after jumps and reports mismatches.
module cpu86_exec_trace_checker #(
  parameter int               REG_W    = 16,
  parameter int               NREGS    = 11,
  parameter int               DEPTH    = 8,
  parameter int               MODE     = 1,
  parameter logic [4:0]       XCHG_OP  = 5'b10000,
  parameter logic [REG_W-1:0] FL_MASK  = 16'hFFFF,
  parameter int               SKIP_MAX = 16,
  parameter int               CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clr,
  input  logic                   dut_valid,
  input  logic [4:0]             dut_op,
  input  logic [NREGS*REG_W-1:0] dut_regs,
  input  logic                   ref_valid,
  output logic                   ref_ready,
  input  logic [NREGS*REG_W-1:0] ref_regs,
  input  logic                   ref_jumped,
  input  logic [REG_W-1:0]       ref_new_cs,
  input  logic [REG_W-1:0]       ref_new_ip,
  output logic                   mis_valid,
  output logic [NREGS-1:0]       mis_mask,
  output logic [CNT_W-1:0]       cmp_count,
  output logic [CNT_W-1:0]       err_count,
  output logic [CNT_W-1:0]       skip_count,
  output logic                   first_valid,
  output logic [4:0]             first_op,
  output logic [NREGS*REG_W-1:0] first_dut,
  output logic                   overflow,
  output logic                   sync_timeout
);
  localparam int AW  = $clog2(DEPTH);
  localparam int SKW = $clog2(SKIP_MAX + 2);
  localparam int RW  = NREGS * REG_W;

  typedef enum logic {ST_CMP, ST_SKIP} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Lanes 0/1 (CS:IP) are always checked; the flags lane ignores undefined bits.
  function automatic logic [NREGS-1:0] lane_diff(input logic [RW-1:0] d,
                                                 input logic [RW-1:0] r,
                                                 input logic [4:0]    op);
    logic [REG_W-1:0] a, b;
    logic             sel_all;
    lane_diff = '0;
    sel_all   = (MODE == 2) || ((MODE == 1) && (op == XCHG_OP));
    for (int i = 0; i < NREGS; i++) begin
      a = d[i*REG_W +: REG_W];
      b = r[i*REG_W +: REG_W];
      if (i == NREGS - 1) begin
        a = a & FL_MASK;
        b = b & FL_MASK;
      end
      if (i < 2 || sel_all) lane_diff[i] = (a != b);
    end
  endfunction

  logic [RW-1:0]    r_mem   [DEPTH];
  logic [4:0]       r_opmem [DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  state_t           r_state, w_state_nxt;
  logic [REG_W-1:0] r_tgt_cs, r_tgt_ip;
  logic [SKW-1:0]   r_skip_cnt;

  logic             w_empty, w_full, w_push, w_pop, w_drop;
  logic             w_pop_cmp, w_pop_skip, w_timeout, w_tgt_hit, w_ref_ready;
  logic [RW-1:0]    w_head;
  logic [4:0]       w_head_op;
  logic [NREGS-1:0] w_diff;

  logic             r_mis_valid, r_first_valid, r_overflow, r_sync_timeout;
  logic [NREGS-1:0] r_mis_mask;
  logic [CNT_W-1:0] r_cmp_count, r_err_count, r_skip_count;
  logic [4:0]       r_first_op;
  logic [RW-1:0]    r_first_dut;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head    = r_mem[r_rptr[AW-1:0]];
  assign w_head_op = r_opmem[r_rptr[AW-1:0]];
  assign w_tgt_hit = (w_head[0 +: REG_W] == r_tgt_cs) && (w_head[REG_W +: REG_W] == r_tgt_ip);
  assign w_diff    = lane_diff(w_head, ref_regs, w_head_op);
  assign w_pop     = w_pop_cmp | w_pop_skip;
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign w_push    = dut_valid && (!w_full || w_pop);
  assign w_drop    = dut_valid && w_full && !w_pop;

  always_comb begin
    w_state_nxt = r_state;
    w_ref_ready = 1'b0;
    w_pop_cmp   = 1'b0;
    w_pop_skip  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_CMP: begin
        w_ref_ready = !w_empty && ref_valid;
        w_pop_cmp   = w_ref_ready;
        if (w_pop_cmp && ref_jumped) w_state_nxt = ST_SKIP;
      end
      ST_SKIP: begin
        if (!w_empty) begin
          if (w_tgt_hit) begin
            w_state_nxt = ST_CMP;
          end else begin
            w_pop_skip = 1'b1;
            if (r_skip_cnt == SKW'(SKIP_MAX)) begin
              w_timeout   = 1'b1;
              w_state_nxt = ST_CMP;
            end
          end
        end
      end
      default: w_state_nxt = ST_CMP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]]   <= dut_regs;
      r_opmem[r_wptr[AW-1:0]] <= dut_op;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_state    <= ST_CMP;
      r_tgt_cs   <= '0;
      r_tgt_ip   <= '0;
      r_skip_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_pop_cmp && ref_jumped) begin
        r_tgt_cs   <= ref_new_cs;
        r_tgt_ip   <= ref_new_ip;
        r_skip_cnt <= '0;
      end else if (w_pop_skip) begin
        r_skip_cnt <= r_skip_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_tgt_cs <= '0;
        r_tgt_ip <= '0;
      end
    end
  end

  // Result stage: compare outcome of the popped record, visible one edge after the pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mis_valid    <= 1'b0;
      r_mis_mask     <= '0;
      r_cmp_count    <= '0;
      r_err_count    <= '0;
      r_skip_count   <= '0;
      r_first_valid  <= 1'b0;
      r_first_op     <= '0;
      r_first_dut    <= '0;
      r_overflow     <= 1'b0;
      r_sync_timeout <= 1'b0;
    end else begin
      r_mis_valid <= w_pop_cmp && (|w_diff);
      r_mis_mask  <= w_pop_cmp ? w_diff : '0;
      if (clr) begin
        r_cmp_count    <= '0;
        r_err_count    <= '0;
        r_skip_count   <= '0;
        r_first_valid  <= 1'b0;
        r_first_op     <= '0;
        r_first_dut    <= '0;
        r_overflow     <= 1'b0;
        r_sync_timeout <= 1'b0;
      end else begin
        if (w_pop_cmp) r_cmp_count <= sat_inc(r_cmp_count);
        if (w_pop_cmp && (|w_diff)) begin
          r_err_count <= sat_inc(r_err_count);
          if (!r_first_valid) begin
            r_first_valid <= 1'b1;
            r_first_op    <= w_head_op;
            r_first_dut   <= w_head;
          end
        end
        if (w_pop_skip) r_skip_count   <= sat_inc(r_skip_count);
        if (w_timeout)  r_sync_timeout <= 1'b1;
        if (w_drop)     r_overflow     <= 1'b1;
      end
    end
  end

  assign ref_ready    = w_ref_ready;
  assign mis_valid    = r_mis_valid;
  assign mis_mask     = r_mis_mask;
  assign cmp_count    = r_cmp_count;
  assign err_count    = r_err_count;
  assign skip_count   = r_skip_count;
  assign first_valid  = r_first_valid;
  assign first_op     = r_first_op;
  assign first_dut    = r_first_dut;
  assign overflow     = r_overflow;
  assign sync_timeout = r_sync_timeout;
endmodule
